// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    // Access size/sign encodings carried on ex_mem_type
    typedef enum logic [2:0] {
        MT_B  = 3'b000,
        MT_H  = 3'b001,
        MT_W  = 3'b010,
        MT_BU = 3'b100,
        MT_HU = 3'b101
    } mem_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    // Request payload presented on the data bus
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } dbus_req_t;

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatter: store byte enables / lane replication, load lane
// extraction with sign or zero extension, and alignment check.
//   mem_type, addr_lo : access size/sign and low address bits
//   store_data        : raw store operand
//   rdata             : raw bus read word
//   be_c, wdata_c     : byte enables and replicated store data
//   load_c            : extracted, extended load result
//   misalign_c        : access not naturally aligned
module mem_lane_fmt
    import mem_stage_pkg::*;
(
    input  logic [2:0]        mem_type,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] rdata,
    output logic [BE_W-1:0]   be_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic [DATA_W-1:0] load_c,
    output logic              misalign_c
);

    logic [DATA_W-1:0] shifted;

    // Bring the addressed lane down to bit 0 before extension
    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        be_c       = '1;
        wdata_c    = store_data;
        load_c     = rdata;
        misalign_c = (addr_lo != 2'b00);
        case (mem_type)
            MT_B, MT_BU: begin
                be_c       = BE_W'(4'b0001 << addr_lo);
                wdata_c    = {4{store_data[7:0]}};
                load_c     = (mem_type == MT_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                                : {24'h0, shifted[7:0]};
                misalign_c = 1'b0;
            end
            MT_H, MT_HU: begin
                be_c       = BE_W'(4'b0011 << addr_lo);
                wdata_c    = {2{store_data[15:0]}};
                load_c     = (mem_type == MT_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                                : {16'h0, shifted[15:0]};
                misalign_c = addr_lo[0];
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues byte/half/word loads and stores on a
// valid/ready data bus, stalls upstream while busy, registers write-back.
//   clk, rstn          : clock, synchronous active-low reset
//   ex_*               : instruction from execute, held while mem_stall=1
//   mem_stall          : stage busy
//   dbus_*             : data bus request / response
//   wb_*               : registered write-back result, wb_valid pulses once
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_aluout,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [2:0]        ex_mem_type,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    output logic              mem_stall,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [BE_W-1:0]   dbus_be,
    output logic [DATA_W-1:0] dbus_wdata,
    input  logic              dbus_ready,
    input  logic              dbus_rvalid,
    input  logic [DATA_W-1:0] dbus_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_misalign
);

    state_e            state_q, state_d;
    dbus_req_t         bus_q, bus_d;
    logic              req_q, req_d;
    logic [2:0]        type_q, type_d;
    logic [1:0]        lo_q, lo_d;
    logic [4:0]        rd_q, rd_d;
    logic              rw_q, rw_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_rw_q, wb_rw_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_mis_q, wb_mis_d;

    logic              is_mem;
    logic [2:0]        fmt_type;
    logic [1:0]        fmt_lo;
    logic [BE_W-1:0]   fmt_be;
    logic [DATA_W-1:0] fmt_wdata;
    logic [DATA_W-1:0] fmt_load;
    logic              fmt_misalign;

    assign is_mem = ex_mem_read | ex_mem_write;

    // Formatter sees the live instruction in IDLE and the captured one after
    assign fmt_type = (state_q == S_IDLE) ? ex_mem_type   : type_q;
    assign fmt_lo   = (state_q == S_IDLE) ? ex_aluout[1:0] : lo_q;

    mem_lane_fmt u_fmt (
        .mem_type   (fmt_type),
        .addr_lo    (fmt_lo),
        .store_data (ex_store_data),
        .rdata      (dbus_rdata),
        .be_c       (fmt_be),
        .wdata_c    (fmt_wdata),
        .load_c     (fmt_load),
        .misalign_c (fmt_misalign)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            bus_q      <= '0;
            req_q      <= 1'b0;
            type_q     <= '0;
            lo_q       <= '0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            wb_data_q  <= '0;
            wb_mis_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_q      <= bus_d;
            req_q      <= req_d;
            type_q     <= type_d;
            lo_q       <= lo_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            wb_data_q  <= wb_data_d;
            wb_mis_q   <= wb_mis_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        bus_d      = bus_q;
        req_d      = req_q;
        type_d     = type_q;
        lo_d       = lo_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_rw_d    = wb_rw_q;
        wb_data_d  = wb_data_q;
        wb_mis_d   = wb_mis_q;

        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_aluout;
                        wb_rd_d    = ex_rd;
                        wb_rw_d    = ex_reg_write;
                        wb_mis_d   = 1'b0;
                    end else if (fmt_misalign) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ex_rd;
                        wb_rw_d    = 1'b0;
                        wb_mis_d   = 1'b1;
                    end else begin
                        bus_d.we    = ex_mem_write;
                        bus_d.addr  = {ex_aluout[ADDR_W-1:2], 2'b00};
                        bus_d.be    = fmt_be;
                        bus_d.wdata = fmt_wdata;
                        req_d       = 1'b1;
                        type_d      = ex_mem_type;
                        lo_d        = ex_aluout[1:0];
                        rd_d        = ex_rd;
                        rw_d        = ex_reg_write & ~ex_mem_write;
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dbus_ready) begin
                    req_d = 1'b0;
                    if (bus_q.we) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_rw_d    = 1'b0;
                        wb_mis_d   = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dbus_rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = fmt_load;
                    wb_rd_d    = rd_q;
                    wb_rw_d    = rw_q;
                    wb_mis_d   = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_stall    = (state_q != S_IDLE);
    assign dbus_req     = req_q;
    assign dbus_we      = bus_q.we;
    assign dbus_addr    = bus_q.addr;
    assign dbus_be      = bus_q.be;
    assign dbus_wdata   = bus_q.wdata;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_rw_q;
    assign wb_data      = wb_data_q;
    assign wb_misalign  = wb_mis_q;

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_aluout = '0;
    logic [31:0] ex_store_data = '0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic [2:0]  ex_mem_type = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0;
    logic        mem_stall;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ready = 1'b0;
    logic        dbus_rvalid = 1'b0;
    logic [31:0] dbus_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        wb_misalign;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rstn(rstn),
        .ex_valid(ex_valid), .ex_aluout(ex_aluout), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_type(ex_mem_type),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .mem_stall(mem_stall),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_ready(dbus_ready), .dbus_rvalid(dbus_rvalid),
        .dbus_rdata(dbus_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_data(wb_data), .wb_misalign(wb_misalign)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          chk_data;
        bit          chk_rd;
        logic [31:0] data;
        logic [4:0]  rd;
        bit          rw;
        bit          mis;
    } wb_exp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];

    // Bus model knobs (negative = randomised)
    bit          force_en = 1'b0;
    logic [31:0] force_val = '0;
    int          ready_delay = -1;
    int          rv_delay = -1;
    int          stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic timeout(input string what);
        checks++;
        failures++;
        $display("FAIL timeout %s: got no progress expected completion", what);
        finish_run();
    endtask

    // Memory contents seen by the bus model
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (force_en) return force_val;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    // Reference model: compute expected bus request and write-back result
    task automatic push_expect(input bit rd_en, input bit wr_en, input logic [2:0] mt,
                               input logic [31:0] alu, input logic [31:0] sd,
                               input logic [4:0] rd, input bit rw);
        wb_exp_t         e;
        bus_exp_t        b;
        int              n;
        int              off;
        bit              sgn;
        longint unsigned w;
        longint          v;
        off = int'(alu[1:0]);
        case (mt)
            3'b000: begin n = 1; sgn = 1'b1; end
            3'b100: begin n = 1; sgn = 1'b0; end
            3'b001: begin n = 2; sgn = 1'b1; end
            3'b101: begin n = 2; sgn = 1'b0; end
            default: begin n = 4; sgn = 1'b0; end
        endcase
        e = '{chk_data: 1'b0, chk_rd: 1'b0, data: '0, rd: rd, rw: 1'b0, mis: 1'b0};
        if (!(rd_en || wr_en)) begin
            e.chk_data = 1'b1; e.chk_rd = 1'b1; e.data = alu; e.rw = rw;
        end else if ((off % n) != 0) begin
            e.mis = 1'b1;
        end else begin
            b.we    = wr_en;
            b.addr  = alu & 32'hFFFF_FFFC;
            b.be    = 4'(((1 << n) - 1) << off);
            b.wdata = (n == 1) ? sd[7:0] * 32'h0101_0101 :
                      (n == 2) ? sd[15:0] * 32'h0001_0001 : sd;
            bus_q.push_back(b);
            if (!wr_en) begin
                w = 64'(mem_word(b.addr));
                v = longint'((w >> (8 * off)) & ((64'd1 << (8 * n)) - 1));
                if (sgn && v >= longint'(64'd1 << (8 * n - 1))) v = v - longint'(64'd1 << (8 * n));
                e.chk_data = 1'b1; e.chk_rd = 1'b1; e.data = v[31:0]; e.rw = rw;
            end
        end
        wb_q.push_back(e);
    endtask

    // Present an instruction and hold it until the stage accepts it
    task automatic issue(input bit rd_en, input bit wr_en, input logic [2:0] mt,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input bit rw);
        int guard = 0;
        ex_valid = 1'b1; ex_mem_read = rd_en; ex_mem_write = wr_en; ex_mem_type = mt;
        ex_aluout = alu; ex_store_data = sd; ex_rd = rd; ex_reg_write = rw;
        while (mem_stall) begin
            @(negedge clk);
            guard++;
            if (guard > 100) timeout("issue");
        end
        push_expect(rd_en, wr_en, mt, alu, sd, rd, rw);
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (wb_q.size() != 0 || mem_stall) begin
            @(negedge clk);
            guard++;
            if (guard > 200) timeout("wait_idle");
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_mem_stall", 32'(mem_stall), 32'd0);
        chk("rst_dbus_req", 32'(dbus_req), 32'd0);
        chk("rst_dbus_we", 32'(dbus_we), 32'd0);
        chk("rst_dbus_addr", dbus_addr, 32'd0);
        chk("rst_dbus_be", 32'(dbus_be), 32'd0);
        chk("rst_dbus_wdata", dbus_wdata, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_misalign", 32'(wb_misalign), 32'd0);
    endtask

    // Monitor: pop the scoreboard on every write-back pulse
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && wb_valid) begin
                if (wb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d expected no pending result", wb_rd);
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                    chk("wb_misalign", 32'(wb_misalign), 32'(e.mis));
                    if (e.chk_data) chk("wb_data", wb_data, e.data);
                    if (e.chk_rd) chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                end
            end
            if (mem_stall) stall_cnt++;
        end
    end

    // Bus responder: variable ready latency, read data after the handshake
    bit          in_req = 1'b0;
    int          wait_left = 0;
    int          cur_delay = 0;
    int          req_cycles = 0;
    int          rv_cnt = 0;
    logic [31:0] rv_addr = '0;
    bus_exp_t    cp;

    initial begin
        bus_exp_t e;
        forever begin
            @(negedge clk);
            dbus_ready  = 1'b0;
            dbus_rvalid = 1'b0;
            dbus_rdata  = $urandom;
            if (!rstn) in_req = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    dbus_rvalid = 1'b1;
                    dbus_rdata  = mem_word(rv_addr);
                end
            end else if (rstn && dbus_req) begin
                if (!in_req) begin
                    in_req     = 1'b1;
                    req_cycles = 0;
                    cur_delay  = (ready_delay >= 0) ? ready_delay : int'($urandom_range(0, 3));
                    wait_left  = cur_delay;
                    cp = '{we: dbus_we, addr: dbus_addr, be: dbus_be, wdata: dbus_wdata};
                    if (bus_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL dbus_unexpected: got req addr=%h expected no bus access", dbus_addr);
                    end else begin
                        e = bus_q.pop_front();
                        chk("dbus_we", 32'(dbus_we), 32'(e.we));
                        chk("dbus_addr", dbus_addr, e.addr);
                        chk("dbus_be", 32'(dbus_be), 32'(e.be));
                        if (e.we) chk("dbus_wdata", dbus_wdata, e.wdata);
                    end
                end else begin
                    chk("dbus_hold", 32'(dbus_we == cp.we && dbus_addr == cp.addr &&
                                         dbus_be == cp.be && dbus_wdata == cp.wdata), 32'd1);
                end
                req_cycles++;
                if (wait_left == 0) begin
                    dbus_ready = 1'b1;
                    in_req     = 1'b0;
                    chk("dbus_req_cycles", 32'(req_cycles), 32'(cur_delay + 1));
                    if (!dbus_we) begin
                        rv_cnt  = (rv_delay >= 0) ? rv_delay : int'($urandom_range(1, 3));
                        rv_addr = dbus_addr;
                    end
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit          rd_en, wr_en;
        logic [2:0]  mt;
        int          k;
        logic [2:0]  ld_types[5];
        ld_types = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rstn = 1'b1;
        @(negedge clk);

        // Plain ALU pass-through, never stalls
        stall_cnt = 0;
        issue(1'b0, 1'b0, 3'b010, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        wait_idle();
        chk("alu_stall_cycles", 32'(stall_cnt), 32'd0);

        // SB at 0x103 with immediate ready: one stall cycle
        ready_delay = 0;
        stall_cnt = 0;
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 5'd7, 1'b1);
        wait_idle();
        chk("sb_stall_cycles", 32'(stall_cnt), 32'd1);

        // LH / LHU at 0x202, ready delayed 3 cycles
        force_en = 1'b1; force_val = 32'h8001_0000;
        ready_delay = 3; rv_delay = 1;
        stall_cnt = 0;
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0, 5'd9, 1'b1);
        wait_idle();
        chk("lh_stall_cycles", 32'(stall_cnt), 32'd5);
        issue(1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0, 5'd10, 1'b1);
        wait_idle();
        force_en = 1'b0;

        // Misaligned LW: no bus access, no stall
        ready_delay = -1; rv_delay = -1;
        stall_cnt = 0;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0206, 32'h0, 5'd11, 1'b1);
        wait_idle();
        chk("mis_stall_cycles", 32'(stall_cnt), 32'd0);

        // LB followed immediately by an ALU op held behind the stall
        ready_delay = 0; rv_delay = 2;
        stall_cnt = 0;
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0010, 32'h0, 5'd12, 1'b1);
        issue(1'b0, 1'b0, 3'b000, 32'h0000_0F0F, 32'h0, 5'd13, 1'b1);
        wait_idle();
        chk("b2b_stall_cycles", 32'(stall_cnt), 32'd3);

        // Reset while waiting for read data; the late rvalid must be ignored
        ready_delay = 0; rv_delay = 6;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd14, 1'b1);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        wb_q.delete();
        check_reset_outputs();
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_reset_stall", 32'(mem_stall), 32'd0);
        ready_delay = -1; rv_delay = -1;

        // Randomised mix
        for (int i = 0; i < 300; i++) begin
            k = int'($urandom_range(0, 9));
            rd_en = (k >= 3 && k <= 6);
            wr_en = (k >= 7);
            mt = wr_en ? 3'($urandom_range(0, 2)) : ld_types[$urandom_range(0, 4)];
            if (k < 3) mt = 3'($urandom);
            issue(rd_en, wr_en, mt, $urandom, $urandom, 5'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        wait_idle();
        repeat (4) @(negedge clk);
        chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
        chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);
        finish_run();
    end

endmodule
